// File: rtl/bus_datapath_seq.sv
// Single-bus register-file datapath with a built-in micro-step sequencer.
// One start pulse runs a whole register-to-register instruction.
module bus_datapath_seq #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 16,
   localparam int unsigned REG_AW = $clog2(NREGS)
) (
   input  logic              i_clock,
   input  logic              i_clear,
   input  logic              i_start,
   input  logic [3:0]        i_op,
   input  logic [REG_AW-1:0] i_rd,
   input  logic [REG_AW-1:0] i_rs,
   input  logic [REG_AW-1:0] i_rt,
   input  logic [DATA_W-1:0] i_imm,
   input  logic [DATA_W-1:0] i_inport_data,
   input  logic              i_inport_strobe,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_result,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo,
   output logic [DATA_W-1:0] o_outport_data,
   output logic [DATA_W-1:0] o_bus
);
   localparam int unsigned SH_W = $clog2(DATA_W);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_ROL  = 4'd8;
   localparam logic [3:0] OP_ROR  = 4'd9;
   localparam logic [3:0] OP_NOT  = 4'd10;
   localparam logic [3:0] OP_NEG  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;
   localparam logic [3:0] OP_ADDI = 4'd13;
   localparam logic [3:0] OP_IN   = 4'd14;
   localparam logic [3:0] OP_OUT  = 4'd15;

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4, S_DONE} state_t;

   state_t              r_state;
   logic [3:0]          r_op;
   logic [REG_AW-1:0]   r_rd, r_rs, r_rt;
   logic [DATA_W-1:0]   r_imm;
   logic [DATA_W-1:0]   r_regs [NREGS];
   logic [DATA_W-1:0]   r_y, r_hi, r_lo, r_inport, r_outport;
   logic [2*DATA_W-1:0] r_z;
   logic                r_busy, r_done;

   logic [DATA_W-1:0]   w_bus;
   logic [DATA_W-1:0]   w_alu_lo;
   logic [2*DATA_W-1:0] w_alu;
   logic [SH_W-1:0]     w_sh, w_rot;
   logic [2*DATA_W-1:0] w_rol2, w_ror2, w_prod;

   // Shared bus source select, driven purely by the current micro-step
   always_comb begin
      w_bus = '0;
      case (r_state)
         S_T1:    w_bus = (r_op == OP_IN) ? r_inport : r_regs[r_rs];
         S_T2:    w_bus = (r_op == OP_ADDI) ? r_imm : r_regs[r_rt];
         S_T3:    w_bus = r_z[DATA_W-1:0];
         S_T4:    w_bus = r_z[2*DATA_W-1:DATA_W];
         default: w_bus = '0;
      endcase
   end

   // Rotates go through a doubled word so any amount below DATA_W wraps cleanly
   assign w_sh   = w_bus[SH_W-1:0];
   assign w_rot  = SH_W'(32'(w_sh) % DATA_W);
   assign w_rol2 = {r_y, r_y} << w_rot;
   assign w_ror2 = {r_y, r_y} >> w_rot;
   assign w_prod = $unsigned($signed({{DATA_W{r_y[DATA_W-1]}}, r_y}) *
                             $signed({{DATA_W{w_bus[DATA_W-1]}}, w_bus}));

   always_comb begin
      w_alu_lo = '0;
      case (r_op)
         OP_ADD:  w_alu_lo = r_y + w_bus;
         OP_SUB:  w_alu_lo = r_y - w_bus;
         OP_AND:  w_alu_lo = r_y & w_bus;
         OP_OR:   w_alu_lo = r_y | w_bus;
         OP_XOR:  w_alu_lo = r_y ^ w_bus;
         OP_SHL:  w_alu_lo = r_y << w_sh;
         OP_SHR:  w_alu_lo = r_y >> w_sh;
         OP_SRA:  w_alu_lo = $unsigned($signed(r_y) >>> w_sh);
         OP_ROL:  w_alu_lo = w_rol2[2*DATA_W-1:DATA_W];
         OP_ROR:  w_alu_lo = w_ror2[DATA_W-1:0];
         OP_NOT:  w_alu_lo = ~w_bus;
         OP_NEG:  w_alu_lo = DATA_W'(0) - w_bus;
         OP_ADDI: w_alu_lo = r_y + w_bus;
         default: w_alu_lo = '0;
      endcase
      w_alu = (r_op == OP_MUL) ? w_prod : {DATA_W'(0), w_alu_lo};
   end

   // Sequencer and all datapath registers; clear wins over everything
   always_ff @(posedge i_clock) begin
      if (i_clear) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_rd      <= '0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_imm     <= '0;
         r_y       <= '0;
         r_z       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_inport  <= '0;
         r_outport <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         if (i_inport_strobe) r_inport <= i_inport_data;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_op    <= i_op;
                  r_rd    <= i_rd;
                  r_rs    <= i_rs;
                  r_rt    <= i_rt;
                  r_imm   <= i_imm;
                  r_state <= S_T1;
                  r_busy  <= 1'b1;
               end
            end
            S_T1: begin
               if (r_op == OP_IN || r_op == OP_OUT) begin
                  if (r_op == OP_IN) r_regs[r_rd] <= w_bus;
                  else               r_outport    <= w_bus;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_y     <= w_bus;
                  r_state <= S_T2;
               end
            end
            S_T2: begin
               r_z     <= w_alu;
               r_state <= S_T3;
            end
            S_T3: begin
               if (r_op == OP_MUL) begin
                  r_lo    <= w_bus;
                  r_state <= S_T4;
               end else begin
                  r_regs[r_rd] <= w_bus;
                  r_state      <= S_DONE;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
               end
            end
            S_T4: begin
               r_hi    <= w_bus;
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_result       = r_z[DATA_W-1:0];
   assign o_hi           = r_hi;
   assign o_lo           = r_lo;
   assign o_outport_data = r_outport;
   assign o_bus          = w_bus;

endmodule
